// File: rtl/pwm3_deadtime.sv
// Three-phase center-aligned PWM with per-leg dead-time insertion and a latched hardware trip.
// Compare values are shadowed at carrier zero; all gate outputs are registered.
module pwm3_deadtime #(
  parameter int PERIOD   = 3750,
  parameter int DEADTIME = 150
) (
  input  logic        clk,
  input  logic        global_rst,
  input  logic [15:0] cmp_a,
  input  logic [15:0] cmp_b,
  input  logic [15:0] cmp_c,
  input  logic [15:0] ctrl,
  input  logic        trip_n,
  output logic        pwm_ah,
  output logic        pwm_al,
  output logic        pwm_bh,
  output logic        pwm_bl,
  output logic        pwm_ch,
  output logic        pwm_cl,
  output logic        pwm_sync,
  output logic [15:0] pwm_cnt,
  output logic        fault_flag
);

  localparam logic [15:0] PER = 16'(PERIOD);
  localparam logic [15:0] DT  = 16'(DEADTIME);

  logic        en_s;
  logic        clr_s;
  logic [13:0] ctrl_unused_s;
  logic        load_s;
  logic        sync_next_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_next_s;
  logic        up_r;
  logic        up_next_s;
  logic [15:0] cmp_s      [3];
  logic [15:0] eff_s      [3];
  logic [15:0] shadow_r   [3];
  logic [15:0] dt_r       [3];
  logic [15:0] dt_next_s  [3];
  logic [2:0]  raw_s;
  logic [2:0]  raw_d_r;
  logic [2:0]  raw_d_next_s;
  logic [2:0]  on_s;
  logic [2:0]  hi_r;
  logic [2:0]  lo_r;
  logic        sync_r;
  logic        trip_meta_r;
  logic        trip_sync_r;
  logic        fault_r;
  logic        fault_next_s;

  assign en_s          = ctrl[0];
  assign clr_s         = ctrl[1];
  assign ctrl_unused_s = ctrl[15:2];
  assign cmp_s[0]      = cmp_a;
  assign cmp_s[1]      = cmp_b;
  assign cmp_s[2]      = cmp_c;
  // Shadows follow the inputs while idle and reload only at carrier zero while running.
  assign load_s        = !en_s || (cnt_r == 16'd0);
  assign sync_next_s   = en_s && (cnt_r == 16'd0);

  // Up/down carrier next state; direction turns at PERIOD and at zero.
  always_comb begin
    cnt_next_s = cnt_r;
    up_next_s  = up_r;
    if (!en_s) begin
      cnt_next_s = 16'd0;
      up_next_s  = 1'b1;
    end else if (up_r) begin
      if (cnt_r >= PER) begin
        cnt_next_s = cnt_r - 16'd1;
        up_next_s  = 1'b0;
      end else begin
        cnt_next_s = cnt_r + 16'd1;
        up_next_s  = 1'b1;
      end
    end else begin
      if (cnt_r == 16'd0) begin
        cnt_next_s = cnt_r + 16'd1;
        up_next_s  = 1'b1;
      end else begin
        cnt_next_s = cnt_r - 16'd1;
        up_next_s  = 1'b0;
      end
    end
  end

  // Fault latch: a synchronized trip wins over a clear request in the same cycle.
  always_comb begin
    fault_next_s = fault_r;
    if (!trip_sync_r) begin
      fault_next_s = 1'b1;
    end else if (clr_s) begin
      fault_next_s = 1'b0;
    end else begin
      fault_next_s = fault_r;
    end
  end

  // Per-phase raw compare and dead-band sequencing; the mismatch cycle counts as the first dead cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      eff_s[i]        = load_s ? cmp_s[i] : shadow_r[i];
      dt_next_s[i]    = 16'd0;
      raw_d_next_s[i] = 1'b0;
      on_s[i]         = 1'b0;
      if (eff_s[i] == 16'd0) begin
        raw_s[i] = 1'b0;
      end else if (eff_s[i] >= PER) begin
        raw_s[i] = 1'b1;
      end else begin
        raw_s[i] = (cnt_r < eff_s[i]);
      end
      if (!en_s) begin
        raw_d_next_s[i] = raw_s[i];
      end else if (fault_next_s) begin
        // Park the edge detector inverted so release always starts with a full dead band.
        dt_next_s[i]    = DT;
        raw_d_next_s[i] = ~raw_s[i];
      end else if (raw_s[i] != raw_d_r[i]) begin
        dt_next_s[i]    = DT;
        raw_d_next_s[i] = raw_s[i];
        on_s[i]         = (DT == 16'd0);
      end else if (dt_r[i] != 16'd0) begin
        dt_next_s[i]    = dt_r[i] - 16'd1;
        raw_d_next_s[i] = raw_s[i];
        on_s[i]         = (dt_r[i] == 16'd1);
      end else begin
        raw_d_next_s[i] = raw_s[i];
        on_s[i]         = 1'b1;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous gate-driver trip.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      trip_meta_r <= 1'b1;
      trip_sync_r <= 1'b1;
    end else begin
      trip_meta_r <= trip_n;
      trip_sync_r <= trip_meta_r;
    end
  end

  // Carrier, shadows, dead-time state and registered gate outputs.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      cnt_r   <= 16'd0;
      up_r    <= 1'b1;
      sync_r  <= 1'b0;
      fault_r <= 1'b0;
      raw_d_r <= 3'b000;
      hi_r    <= 3'b000;
      lo_r    <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        shadow_r[i] <= 16'd0;
        dt_r[i]     <= 16'd0;
      end
    end else begin
      cnt_r   <= cnt_next_s;
      up_r    <= up_next_s;
      sync_r  <= sync_next_s;
      fault_r <= fault_next_s;
      raw_d_r <= raw_d_next_s;
      hi_r    <= on_s & raw_s;
      lo_r    <= on_s & ~raw_s;
      for (int i = 0; i < 3; i++) begin
        shadow_r[i] <= eff_s[i];
        dt_r[i]     <= dt_next_s[i];
      end
    end
  end

  assign pwm_ah     = hi_r[0];
  assign pwm_al     = lo_r[0];
  assign pwm_bh     = hi_r[1];
  assign pwm_bl     = lo_r[1];
  assign pwm_ch     = hi_r[2];
  assign pwm_cl     = lo_r[2];
  assign pwm_sync   = sync_r;
  assign pwm_cnt    = cnt_r;
  assign fault_flag = fault_r;

endmodule

// File: tb/tb_pwm3_deadtime.sv
// Directed bench for pwm3_deadtime with PERIOD=10, DEADTIME=2 (20-cycle carrier).
// Samples are taken on the falling edge; k counts falling edges since enable.
module tb_pwm3_deadtime;

  logic        clk;
  logic        global_rst;
  logic [15:0] cmp_a, cmp_b, cmp_c, ctrl;
  logic        trip_n;
  logic        pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl;
  logic        pwm_sync;
  logic [15:0] pwm_cnt;
  logic        fault_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int c_ah, c_al, c_bh, c_bl, c_ch, c_cl, c_sync, c_dead_a;

  pwm3_deadtime #(.PERIOD(10), .DEADTIME(2)) dut (
    .clk(clk), .global_rst(global_rst),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_c(cmp_c), .ctrl(ctrl), .trip_n(trip_n),
    .pwm_ah(pwm_ah), .pwm_al(pwm_al), .pwm_bh(pwm_bh), .pwm_bl(pwm_bl),
    .pwm_ch(pwm_ch), .pwm_cl(pwm_cl), .pwm_sync(pwm_sync),
    .pwm_cnt(pwm_cnt), .fault_flag(fault_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick();
  endtask

  task automatic win(input int n);
    c_ah = 0; c_al = 0; c_bh = 0; c_bl = 0; c_ch = 0; c_cl = 0; c_sync = 0; c_dead_a = 0;
    repeat (n) begin
      tick();
      c_ah += int'(pwm_ah); c_al += int'(pwm_al);
      c_bh += int'(pwm_bh); c_bl += int'(pwm_bl);
      c_ch += int'(pwm_ch); c_cl += int'(pwm_cl);
      c_sync += int'(pwm_sync);
      c_dead_a += int'(!pwm_ah && !pwm_al);
    end
  endtask

  function automatic logic [5:0] gates();
    return {pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl};
  endfunction

  // Shoot-through watchdog on every sample while out of reset.
  always @(negedge clk) begin
    if (global_rst) begin
      check("overlap_a", 32'(pwm_ah & pwm_al), 32'd0);
      check("overlap_b", 32'(pwm_bh & pwm_bl), 32'd0);
      check("overlap_c", 32'(pwm_ch & pwm_cl), 32'd0);
    end
  end

  initial begin
    global_rst = 1'b1;
    cmp_a = 16'd5; cmp_b = 16'd3; cmp_c = 16'd10;
    ctrl = 16'h0000; trip_n = 1'b1;
    #1 global_rst = 1'b0;
    @(negedge clk);
    check("rst_gates", 32'(gates()), 32'd0);
    check("rst_cnt", 32'(pwm_cnt), 32'd0);
    check("rst_fault", 32'(fault_flag), 32'd0);
    check("rst_sync", 32'(pwm_sync), 32'd0);
    global_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cnt", 32'(pwm_cnt), 32'd0);
    check("idle_gates", 32'(gates()), 32'd0);
    check("idle_sync", 32'(pwm_sync), 32'd0);

    // Basic carrier and dead band, cmp_a=5 cmp_b=3 cmp_c=10
    ctrl = 16'h0001;
    k = 0;
    tick();
    check("start_cnt", 32'(pwm_cnt), 32'd1);
    check("start_sync", 32'(pwm_sync), 32'd1);
    check("start_ah", 32'(pwm_ah), 32'd1);
    tick_to(6);
    check("db_fall_a", 32'({pwm_ah, pwm_al}), 32'd0);
    tick_to(8);
    check("al_on", 32'({pwm_ah, pwm_al}), 32'd1);
    tick_to(19);
    check("ah_back", 32'({pwm_ah, pwm_al}), 32'd2);
    tick_to(20);
    check("zero_cnt", 32'(pwm_cnt), 32'd0);
    check("zero_nosync", 32'(pwm_sync), 32'd0);
    win(20);
    check("win_ah", 32'(c_ah), 32'd7);
    check("win_al", 32'(c_al), 32'd9);
    check("win_bh", 32'(c_bh), 32'd3);
    check("win_bl", 32'(c_bl), 32'd13);
    check("win_ch", 32'(c_ch), 32'd20);
    check("win_cl", 32'(c_cl), 32'd0);
    check("win_sync", 32'(c_sync), 32'd1);

    // cmp_a -> 0 mid-period: old duty persists until the next zero
    tick_to(43);
    cmp_a = 16'd0;
    tick_to(45);
    check("cmp0_old_duty", 32'(pwm_ah), 32'd1);
    tick_to(61);
    check("cmp0_db", 32'({pwm_ah, pwm_al}), 32'd0);
    tick_to(80);
    win(5);
    check("cmp0_al_a", 32'(c_al), 32'd5);
    cmp_a = 16'd10;
    win(15);
    check("cmp0_al_b", 32'(c_al), 32'd15);
    check("cmp0_ah_b", 32'(c_ah), 32'd0);
    win(20);
    check("cmp10_ah", 32'(c_ah), 32'd18);
    check("cmp10_dead", 32'(c_dead_a), 32'd2);
    check("cmp10_al", 32'(c_al), 32'd0);
    tick_to(103);
    check("cmp10_steady", 32'({pwm_ah, pwm_al}), 32'd2);

    // cmp_b 3 -> 7 written at cnt=6 counting up
    tick_to(126);
    check("cmpb_cnt6", 32'(pwm_cnt), 32'd6);
    cmp_b = 16'd7;
    tick_to(136);
    check("cmpb_old_mid", 32'({pwm_bh, pwm_bl}), 32'd1);
    tick_to(139);
    check("cmpb_old_db", 32'({pwm_bh, pwm_bl}), 32'd0);
    tick_to(140);
    win(20);
    check("cmpb_new_bh", 32'(c_bh), 32'd11);
    check("cmpb_new_bl", 32'(c_bl), 32'd5);

    // One-cycle trip pulse, then clear
    tick_to(161);
    trip_n = 1'b0;
    tick();
    trip_n = 1'b1;
    tick();
    check("trip_not_yet", 32'(fault_flag), 32'd0);
    tick();
    check("trip_fault", 32'(fault_flag), 32'd1);
    check("trip_gates", 32'(gates()), 32'd0);
    tick_to(170);
    check("trip_hold_fault", 32'(fault_flag), 32'd1);
    check("trip_hold_gates", 32'(gates()), 32'd0);
    check("trip_cnt_runs", 32'(pwm_cnt), 32'd10);
    ctrl = 16'h0003;
    tick();
    ctrl = 16'h0001;
    check("clr_fault", 32'(fault_flag), 32'd0);
    check("clr_db1", 32'(gates()), 32'd0);
    tick();
    check("clr_db2", 32'(gates()), 32'd0);
    tick();
    check("clr_resume", 32'(gates()), 32'(6'b100110));

    // Enable dropped mid-period, then restarted
    tick_to(175);
    ctrl = 16'h0000;
    tick();
    check("dis_cnt", 32'(pwm_cnt), 32'd0);
    check("dis_gates", 32'(gates()), 32'd0);
    check("dis_sync", 32'(pwm_sync), 32'd0);
    tick_to(178);
    check("dis_hold_cnt", 32'(pwm_cnt), 32'd0);
    ctrl = 16'h0001;
    tick();
    check("re_cnt", 32'(pwm_cnt), 32'd1);
    check("re_sync", 32'(pwm_sync), 32'd1);
    check("re_ah", 32'({pwm_ah, pwm_al}), 32'd2);
    tick();
    check("re_cnt2", 32'(pwm_cnt), 32'd2);
    check("re_sync_off", 32'(pwm_sync), 32'd0);

    // Asynchronous reset mid-period while faulted
    tick_to(181);
    trip_n = 1'b0;
    tick_to(184);
    check("pre_rst_fault", 32'(fault_flag), 32'd1);
    tick();
    check("pre_rst_cnt", 32'(pwm_cnt), 32'd7);
    #2 global_rst = 1'b0;
    #1;
    check("arst_gates", 32'(gates()), 32'd0);
    check("arst_cnt", 32'(pwm_cnt), 32'd0);
    check("arst_fault", 32'(fault_flag), 32'd0);
    check("arst_sync", 32'(pwm_sync), 32'd0);
    trip_n = 1'b1;
    repeat (2) @(negedge clk);
    global_rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
